pacman_motion: RTL and testbench
================================

// Module: pacman_motion
// PURPOSE
//  Upstream of the game FSM: owns PacMan's top-left position (pX, pY) and produces it once per frame.
//  Latches WASD keycodes as a queued turn. On each frame tick it probes the maze wall ROM at the
//  leading edge and takes the queued turn if clear. Otherwise it continues in the current
//  direction if clear, else stops. Horizontal tunnel wrap-around is supported.
// PARAMETERS
//  START_X  10'd304  pX after reset/restart
//  START_Y  10'd352  pY after reset/restart
//  SIZE     10'd16   sprite edge in pixels; driven on pSize
//  STEP     10'd1    pixels moved per frame tick (1..SIZE-1)
//  X_LIMIT  10'd624  largest legal pX; tunnel wraps 0 <-> X_LIMIT
// PORTS
//  Clk        in   1   system clock
//  Reset      in   1   synchronous, active-high reset
//  frame_tick in   1   one-cycle pulse per video frame (vsync edge)
//  restart    in   1   from game FSM; same effect as Reset, synchronous
//  run_en     in   1   high while game FSM is in Run; gates motion
//  keycode    in   8   USB keycode: 1A=W up, 16=S down, 04=A left, 07=D right
//  wall_rd_en out  1   ROM read strobe, one cycle per probe
//  wall_rd_x  out  10  probe pixel x
//  wall_rd_y  out  10  probe pixel y
//  wall_hit   in   1   ROM data: 1=wall; valid the cycle after wall_rd_en
//  pX, pY     out  10  PacMan top-left position
//  pSize      out  10  constant SIZE
//  dir        out  2   current direction: 00 up, 01 down, 10 left, 11 right
//  moving     out  1   1 if last frame's evaluation moved PacMan
// BEHAVIOUR
//  - Reset or restart, checked before all other logic: pX=START_X, pY=START_Y, dir=qdir=10 (left),
//    moving=0, wall_rd_en=0, wall_rd_x=wall_rd_y=0, state=IDLE. Aborts any probe in flight.
//  - qdir (queued direction) updates on any clock where keycode is a direction code, in every state.
//    Other codes are ignored.
//  - FSM: IDLE, QA, QB, QW, CA, CB, CW, MOVE.
//  - IDLE, frame_tick & run_en: go to QA if qdir!=dir, else CA. Ticks outside IDLE are dropped.
//  - Probe pair for direction d, with E=SIZE-1:
//      up:    (pX, pY-STEP)     and (pX+E, pY-STEP)
//      down:  (pX, pY+E+STEP)   and (pX+E, pY+E+STEP)
//      left:  (pX-STEP, pY)     and (pX-STEP, pY+E)
//      right: (pX+E+STEP, pY)   and (pX+E+STEP, pY+E)
//  - Probe timing:
//      QA/CA: issue corner A.
//      QB/CB: issue corner B and sample hit A.
//      QW/CW: sample hit B; blocked = hitA|hitB.
//  - Q sequence, clear: dir<=qdir, then MOVE. Blocked: go to CA (keep dir).
//  - C sequence, clear: MOVE. Blocked: moving<=0, go to IDLE.
//  - Out-of-bounds rules, applied without issuing any ROM read; the state still steps through
//    its A/B/W states:
//      up with pY<STEP, or down with pY+E+STEP>479: blocked.
//      left with pX<STEP, or right with pX+STEP>X_LIMIT: tunnel, treated as clear.
//  - MOVE, one cycle:
//      Apply STEP in dir and set moving<=1, then go to IDLE.
//      Left with pX<STEP: pX<=X_LIMIT.
//      Right with pX+STEP>X_LIMIT: pX<=0.
//      All arithmetic is 10-bit unsigned; the bounds checks above prevent underflow.
//  - run_en falling mid-sequence: return to IDLE next cycle. No position change; moving unchanged.
//  - Latency: pX/pY update at most 8 cycles after frame_tick. Position is stable otherwise.
//  - wall_rd_x/y hold their last value when wall_rd_en=0.
// TESTING
//  - Reset, then 3 ticks with run_en=1, no walls -> pX 304->303->302->301; pY=352; dir=10; moving=1.
//  - keycode=1A, wall above at y=351 under either corner -> dir stays 10, moves left.
//    Wall removed -> next tick dir=00, pY=351.
//  - Facing right, wall at x=320 rows 352..367 -> pX=304 holds, moving=0. Queue up (clear) -> pY=351.
//  - pX=0, dir=left, tick -> pX=624 and no wall_rd_en that frame. pX=624, right, tick -> pX=0.
//  - restart asserted in cycle QB -> next cycle pX=304, pY=352, state IDLE, wall_rd_en=0.
//  - frame_tick while run_en=0, and a second tick during QA -> no motion, no extra probe sequence.

Source files
------------

// File: rtl/pacman_motion_if.sv
// Wall ROM read port: probe strobe and pixel coordinate out, wall bit back one cycle later.
interface pacman_motion_if;
  logic       wall_rd_en;
  logic [9:0] wall_rd_x;
  logic [9:0] wall_rd_y;
  logic       wall_hit;

  modport master (
    output wall_rd_en,
    output wall_rd_x,
    output wall_rd_y,
    input  wall_hit
  );

  modport slave (
    input  wall_rd_en,
    input  wall_rd_x,
    input  wall_rd_y,
    output wall_hit
  );
endinterface

// File: rtl/pacman_motion.sv
// PacMan position owner: queues WASD turns, probes the wall ROM once per frame tick and steps
// the sprite, with horizontal tunnel wrap-around.
module pacman_motion #(
  parameter logic [9:0] START_X = 10'd304,
  parameter logic [9:0] START_Y = 10'd352,
  parameter logic [9:0] SIZE    = 10'd16,
  parameter logic [9:0] STEP    = 10'd1,
  parameter logic [9:0] X_LIMIT = 10'd624
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   restart,
  input  logic                   run_en,
  input  logic [7:0]             keycode,
  pacman_motion_if.master        rom,
  output logic [9:0]             pX,
  output logic [9:0]             pY,
  output logic [9:0]             pSize,
  output logic [1:0]             dir,
  output logic                   moving
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] QA   = 3'd1;
  localparam logic [2:0] QB   = 3'd2;
  localparam logic [2:0] QW   = 3'd3;
  localparam logic [2:0] CA   = 3'd4;
  localparam logic [2:0] CB   = 3'd5;
  localparam logic [2:0] CW   = 3'd6;
  localparam logic [2:0] MOVE = 3'd7;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirRight = 2'b11;

  localparam logic [9:0] E = SIZE - 10'd1;

  logic [2:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] qdir_q, qdir_d;
  logic [1:0] pdir_q, pdir_d;
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
  logic       moving_q, moving_d;
  logic       hit_a_q, hit_a_d;
  logic       rd_en_q, rd_en_d;
  logic [9:0] rd_x_q, rd_x_d;
  logic [9:0] rd_y_q, rd_y_d;

  logic       blocked;
  logic       corner_b;
  logic [9:0] probe_x, probe_y;

  function automatic logic edge_blocked(input logic [1:0] d, input logic [9:0] y);
    return (d == DirUp && y < STEP) || (d == DirDown && (y + E + STEP) > 10'd479);
  endfunction

  function automatic logic edge_tunnel(input logic [1:0] d, input logic [9:0] x);
    return (d == DirLeft && x < STEP) || (d == DirRight && (x + STEP) > X_LIMIT);
  endfunction

  always_comb begin
    qdir_d = qdir_q;
    case (keycode)
      8'h1A:   qdir_d = DirUp;
      8'h16:   qdir_d = DirDown;
      8'h04:   qdir_d = DirLeft;
      8'h07:   qdir_d = DirRight;
      default: qdir_d = qdir_q;
    endcase
  end

  // Off-map edges never consult the ROM, so any stale hit data is masked out here.
  assign blocked = edge_blocked(pdir_q, py_q) |
                   (~edge_tunnel(pdir_q, px_q) & (hit_a_q | rom.wall_hit));

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pdir_d   = pdir_q;
    px_d     = px_q;
    py_d     = py_q;
    moving_d = moving_q;
    hit_a_d  = hit_a_q;
    if (state_q != IDLE && !run_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick && run_en) begin
            state_d = (qdir_q != dir_q) ? QA : CA;
            pdir_d  = qdir_q;
          end
        end
        QA: state_d = QB;
        QB: begin
          state_d = QW;
          hit_a_d = rom.wall_hit;
        end
        QW: begin
          if (blocked) begin
            state_d = CA;
            pdir_d  = dir_q;
          end else begin
            state_d = MOVE;
            dir_d   = pdir_q;
          end
        end
        CA: state_d = CB;
        CB: begin
          state_d = CW;
          hit_a_d = rom.wall_hit;
        end
        CW: begin
          if (blocked) begin
            state_d  = IDLE;
            moving_d = 1'b0;
          end else begin
            state_d = MOVE;
          end
        end
        MOVE: begin
          state_d  = IDLE;
          moving_d = 1'b1;
          case (dir_q)
            DirUp:    py_d = py_q - STEP;
            DirDown:  py_d = py_q + STEP;
            DirLeft:  px_d = (px_q < STEP) ? X_LIMIT : px_q - STEP;
            default:  px_d = ((px_q + STEP) > X_LIMIT) ? 10'd0 : px_q + STEP;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read strobe is registered against the next state so it is high during QA/QB and CA/CB.
  assign corner_b = (state_d == QB) || (state_d == CB);

  always_comb begin
    probe_x = px_q;
    probe_y = py_q;
    case (pdir_d)
      DirUp: begin
        probe_x = px_q + (corner_b ? E : 10'd0);
        probe_y = py_q - STEP;
      end
      DirDown: begin
        probe_x = px_q + (corner_b ? E : 10'd0);
        probe_y = py_q + E + STEP;
      end
      DirLeft: begin
        probe_x = px_q - STEP;
        probe_y = py_q + (corner_b ? E : 10'd0);
      end
      default: begin
        probe_x = px_q + E + STEP;
        probe_y = py_q + (corner_b ? E : 10'd0);
      end
    endcase
  end

  always_comb begin
    rd_en_d = (state_d == QA || state_d == QB || state_d == CA || state_d == CB) &&
              !edge_blocked(pdir_d, py_q) && !edge_tunnel(pdir_d, px_q);
    rd_x_d  = rd_en_d ? probe_x : rd_x_q;
    rd_y_d  = rd_en_d ? probe_y : rd_y_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset || restart) begin
      state_q  <= IDLE;
      dir_q    <= DirLeft;
      qdir_q   <= DirLeft;
      pdir_q   <= DirLeft;
      px_q     <= START_X;
      py_q     <= START_Y;
      moving_q <= 1'b0;
      hit_a_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_x_q   <= 10'd0;
      rd_y_q   <= 10'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      qdir_q   <= qdir_d;
      pdir_q   <= pdir_d;
      px_q     <= px_d;
      py_q     <= py_d;
      moving_q <= moving_d;
      hit_a_q  <= hit_a_d;
      rd_en_q  <= rd_en_d;
      rd_x_q   <= rd_x_d;
      rd_y_q   <= rd_y_d;
    end
  end

  assign rom.wall_rd_en = rd_en_q;
  assign rom.wall_rd_x  = rd_x_q;
  assign rom.wall_rd_y  = rd_y_q;
  assign pX     = px_q;
  assign pY     = py_q;
  assign pSize  = SIZE;
  assign dir    = dir_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: per-frame vector table plus restart, tick-drop and tunnel
// sequences, against a one-rectangle wall ROM model.
module tb_pacman_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic       run_en = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] pX, pY, pSize;
  logic [1:0] dir;
  logic       moving;

  pacman_motion_if bus ();

  pacman_motion dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .restart    (restart),
    .run_en     (run_en),
    .keycode    (keycode),
    .rom        (bus.master),
    .pX         (pX),
    .pY         (pY),
    .pSize      (pSize),
    .dir        (dir),
    .moving     (moving)
  );

  always #5 Clk = ~Clk;

  // Wall ROM model: one optional rectangle of wall pixels, one-cycle read latency.
  logic wall_on = 1'b0;
  int   wx0 = 0, wx1 = 0, wy0 = 0, wy1 = 0;
  int   rd_cnt = 0;

  always @(posedge Clk) begin
    bus.wall_hit <= bus.wall_rd_en && wall_on &&
                    int'(bus.wall_rd_x) >= wx0 && int'(bus.wall_rd_x) <= wx1 &&
                    int'(bus.wall_rd_y) >= wy0 && int'(bus.wall_rd_y) <= wy1;
    if (bus.wall_rd_en) rd_cnt <= rd_cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int rd_start;

  task automatic do_frame();
    rd_start = rd_cnt;
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 8'h00;
  endtask

  task automatic pulse_restart();
    @(negedge Clk) restart = 1'b1;
    @(negedge Clk) restart = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] key;
    logic       won;
    int         x0, x1, y0, y1;
    int         ex, ey, ed, em, erd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // rst key won x0 x1 y0 y1 | pX pY dir moving reads
    vecs[0]  = '{1'b0, 8'h00, 1'b0,   0,   0,   0,   0, 303, 352, 2, 1, 2};
    vecs[1]  = '{1'b0, 8'h00, 1'b0,   0,   0,   0,   0, 302, 352, 2, 1, 2};
    vecs[2]  = '{1'b0, 8'h00, 1'b0,   0,   0,   0,   0, 301, 352, 2, 1, 2};
    // up queued, wall above corner B only: turn refused, keeps going left
    vecs[3]  = '{1'b0, 8'h1A, 1'b1, 316, 316, 351, 351, 300, 352, 2, 1, 4};
    vecs[4]  = '{1'b0, 8'h00, 1'b0,   0,   0,   0,   0, 300, 351, 0, 1, 2};
    vecs[5]  = '{1'b1, 8'h00, 1'b0,   0,   0,   0,   0, 303, 352, 2, 1, 2};
    vecs[6]  = '{1'b0, 8'h07, 1'b0,   0,   0,   0,   0, 304, 352, 3, 1, 2};
    // facing right into a wall column at x=320
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 320, 320, 352, 367, 304, 352, 3, 0, 2};
    vecs[8]  = '{1'b0, 8'h1A, 1'b1, 320, 320, 352, 367, 304, 351, 0, 1, 2};
    vecs[9]  = '{1'b0, 8'h05, 1'b0,   0,   0,   0,   0, 304, 350, 0, 1, 2};
    vecs[10] = '{1'b0, 8'h16, 1'b0,   0,   0,   0,   0, 304, 351, 1, 1, 2};

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_px", int'(pX), 304);
    check("reset_py", int'(pY), 352);
    check("reset_dir", int'(dir), 2);
    check("reset_moving", int'(moving), 0);
    check("reset_rd_en", int'(bus.wall_rd_en), 0);
    check("reset_rd_x", int'(bus.wall_rd_x), 0);
    check("reset_rd_y", int'(bus.wall_rd_y), 0);
    check("psize", int'(pSize), 16);
    run_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) pulse_restart();
      if (vecs[i].key != 8'h00) press(vecs[i].key);
      wall_on = vecs[i].won;
      wx0 = vecs[i].x0; wx1 = vecs[i].x1; wy0 = vecs[i].y0; wy1 = vecs[i].y1;
      do_frame();
      check($sformatf("v%0d_px", i), int'(pX), vecs[i].ex);
      check($sformatf("v%0d_py", i), int'(pY), vecs[i].ey);
      check($sformatf("v%0d_dir", i), int'(dir), vecs[i].ed);
      check($sformatf("v%0d_moving", i), int'(moving), vecs[i].em);
      check($sformatf("v%0d_reads", i), rd_cnt - rd_start, vecs[i].erd);
    end
    wall_on = 1'b0;

    // restart while in QB aborts the probe
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    @(negedge Clk);
    check("qb_rd_en", int'(bus.wall_rd_en), 1);
    restart = 1'b1;
    @(negedge Clk) restart = 1'b0;
    check("restart_px", int'(pX), 304);
    check("restart_py", int'(pY), 352);
    check("restart_rd_en", int'(bus.wall_rd_en), 0);
    check("restart_state", int'(dut.state_q), 0);
    check("restart_dir", int'(dir), 2);
    repeat (10) @(negedge Clk);
    check("restart_hold_px", int'(pX), 304);

    // tick while run_en low is ignored
    run_en = 1'b0;
    do_frame();
    check("norun_px", int'(pX), 304);
    check("norun_reads", rd_cnt - rd_start, 0);
    run_en = 1'b1;

    // second tick landing in QA is dropped
    rd_start = rd_cnt;
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk);
    @(negedge Clk) frame_tick = 1'b0;
    repeat (12) @(negedge Clk);
    check("dbltick_px", int'(pX), 303);
    check("dbltick_reads", rd_cnt - rd_start, 2);

    // run_en drop mid-sequence: no move, moving unchanged
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    @(negedge Clk) run_en = 1'b0;
    repeat (10) @(negedge Clk);
    check("abort_px", int'(pX), 303);
    check("abort_moving", int'(moving), 1);
    check("abort_rd_en", int'(bus.wall_rd_en), 0);
    run_en = 1'b1;

    // walk to the left edge, then tunnel both ways
    for (int i = 0; i < 303; i++) do_frame();
    check("edge_px", int'(pX), 0);
    do_frame();
    check("tunnel_l_px", int'(pX), 624);
    check("tunnel_l_reads", rd_cnt - rd_start, 0);
    check("tunnel_l_moving", int'(moving), 1);
    press(8'h07);
    do_frame();
    check("tunnel_r_px", int'(pX), 0);
    check("tunnel_r_dir", int'(dir), 3);
    check("tunnel_r_reads", rd_cnt - rd_start, 0);
    check("tunnel_r_py", int'(pY), 352);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
